// File: rtl/me_stage_pkg.sv
// Shared constants for the memory-access stage: FSM states, opcodes, beat geometry.
package me_stage_pkg;

  localparam int unsigned BeatW    = 32;
  localparam int unsigned MatW     = 512;
  localparam int unsigned Beats    = MatW / BeatW;
  localparam int unsigned BeatIdxW = $clog2(Beats);
  localparam logic [BeatIdxW-1:0] LastBeat = BeatIdxW'(Beats - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} me_state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpFlw   = 7'b0000111;
  localparam logic [6:0] OpFsw   = 7'b0100111;
  localparam logic [6:0] OpSml   = 7'b1111011;
  localparam logic [6:0] OpSms   = 7'b1111111;

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3Bu = 3'b100;
  localparam logic [2:0] F3Hu = 3'b101;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OpLoad) || (op == OpStore) || (op == OpFlw) || (op == OpFsw) ||
           (op == OpSml) || (op == OpSms);
  endfunction

endpackage

// File: rtl/me_load_align.sv
// Load lane select and sign/zero extension of one read beat.
module me_load_align
  import me_stage_pkg::*;
(
  input  logic [2:0]       i_funct3,
  input  logic [1:0]       i_lane,
  input  logic [BeatW-1:0] i_rdata,
  output logic [BeatW-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3B:     o_data = {{24{w_byte[7]}}, w_byte};
      F3Bu:    o_data = {24'b0, w_byte};
      F3H:     o_data = {{16{w_half[15]}}, w_half};
      F3Hu:    o_data = {16'b0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/me_stage.sv
// Memory-access stage: scalar and 16-beat matrix data-cache accesses between EX and WB.
// Optional misaligned-access trapping is enabled by defining ME_MISALIGN_CHK_EN.
module me_stage
  import me_stage_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ex_valid,
  output logic             o_ready,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [31:0]      i_addr,
  input  logic [BeatW-1:0] i_st_r,
  input  logic [BeatW-1:0] i_st_f,
  input  logic [MatW-1:0]  i_st_m,
  input  logic [BeatW-1:0] i_res_r,
  input  logic [BeatW-1:0] i_res_f,
  input  logic [MatW-1:0]  i_res_m,
  input  logic             i_wb_ready,
  output logic             o_me_valid,
  output logic [BeatW-1:0] o_alu_out2_res_r,
  output logic [BeatW-1:0] o_alu_out2_res_f,
  output logic [MatW-1:0]  o_alu_out2_res_m,
  output logic             o_dc_r_valid,
  output logic             o_dc_f_valid,
  output logic             o_dc_m_valid,
  output logic [BeatW-1:0] o_dc_data_r,
  output logic [BeatW-1:0] o_dc_data_f,
  output logic [MatW-1:0]  o_dc_data_m,
  output logic             o_dc_req,
  output logic             o_dc_we,
  output logic [31:0]      o_dc_addr,
  output logic [BeatW-1:0] o_dc_wdata,
  output logic [3:0]       o_dc_wstrb,
  input  logic             i_dc_gnt,
  input  logic             i_dc_rvalid,
  input  logic [BeatW-1:0] i_dc_rdata,
  output logic             o_misalign
);

  me_state_e           r_state, w_state_nxt;
  logic [6:0]          r_op;
  logic [2:0]          r_funct3;
  logic [31:0]         r_addr;
  logic [BeatW-1:0]    r_st_r, r_st_f, r_res_r, r_res_f, r_data_r, r_data_f, w_align;
  logic [MatW-1:0]     r_st_m, r_res_m, r_data_m;
  logic [BeatIdxW-1:0] r_beat;
  logic                r_misalign, w_misalign_in, w_accept, w_in_go, w_is_mat, w_is_store;

`ifdef ME_MISALIGN_CHK_EN
  always_comb begin
    w_misalign_in = 1'b0;
    case (i_opcode)
      OpLoad, OpStore: begin
        if (i_funct3[1:0] == 2'b01)      w_misalign_in = i_addr[0];
        else if (i_funct3[1:0] == 2'b10) w_misalign_in = |i_addr[1:0];
      end
      OpFlw, OpFsw, OpSml, OpSms: w_misalign_in = |i_addr[1:0];
      default: ;
    endcase
  end
`else
  assign w_misalign_in = 1'b0;
`endif

  assign o_ready    = (r_state == StIdle) || ((r_state == StDone) && i_wb_ready);
  assign w_accept   = i_ex_valid && o_ready;
  assign w_in_go    = is_mem_op(i_opcode) && !w_misalign_in;
  assign w_is_mat   = (r_op == OpSml) || (r_op == OpSms);
  assign w_is_store = (r_op == OpStore) || (r_op == OpFsw) || (r_op == OpSms);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: if (i_ex_valid) w_state_nxt = w_in_go ? StReq : StDone;
      StReq:  if (i_dc_gnt) w_state_nxt = StWait;
      StWait: if (i_dc_rvalid) w_state_nxt = (!w_is_mat || r_beat == LastBeat) ? StDone : StReq;
      StDone: if (i_wb_ready) w_state_nxt = !i_ex_valid ? StIdle : (w_in_go ? StReq : StDone);
      default: w_state_nxt = StIdle;
    endcase
  end

  // Store lane placement; driven only while a write request is on the bus.
  always_comb begin
    o_dc_wdata = '0;
    o_dc_wstrb = '0;
    if (r_state == StReq && w_is_store) begin
      case (r_op)
        OpStore: begin
          case (r_funct3[1:0])
            2'b00: begin
              o_dc_wstrb = 4'b0001 << r_addr[1:0];
              o_dc_wdata = {24'b0, r_st_r[7:0]} << {r_addr[1:0], 3'b000};
            end
            2'b01: begin
              o_dc_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
              o_dc_wdata = r_addr[1] ? {r_st_r[15:0], 16'b0} : {16'b0, r_st_r[15:0]};
            end
            default: begin
              o_dc_wstrb = 4'b1111;
              o_dc_wdata = r_st_r;
            end
          endcase
        end
        OpFsw: begin
          o_dc_wstrb = 4'b1111;
          o_dc_wdata = r_st_f;
        end
        default: begin
          o_dc_wstrb = 4'b1111;
          o_dc_wdata = r_st_m[{r_beat, 5'b00000} +: BeatW];
        end
      endcase
    end
  end

  me_load_align u_load_align (
    .i_funct3 (r_funct3),
    .i_lane   (r_addr[1:0]),
    .i_rdata  (i_dc_rdata),
    .o_data   (w_align)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_op       <= '0;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_st_r     <= '0;
      r_st_f     <= '0;
      r_st_m     <= '0;
      r_res_r    <= '0;
      r_res_f    <= '0;
      r_res_m    <= '0;
      r_data_r   <= '0;
      r_data_f   <= '0;
      r_data_m   <= '0;
      r_beat     <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op       <= i_opcode;
        r_funct3   <= i_funct3;
        r_addr     <= i_addr;
        r_st_r     <= i_st_r;
        r_st_f     <= i_st_f;
        r_st_m     <= i_st_m;
        r_res_r    <= i_res_r;
        r_res_f    <= i_res_f;
        r_res_m    <= i_res_m;
        r_beat     <= '0;
        r_misalign <= w_misalign_in;
      end else if (r_state == StDone && i_wb_ready) begin
        r_misalign <= 1'b0;
      end
      if (r_state == StWait && i_dc_rvalid) begin
        if (r_op == OpLoad) r_data_r <= w_align;
        if (r_op == OpFlw)  r_data_f <= i_dc_rdata;
        if (r_op == OpSml)  r_data_m[{r_beat, 5'b00000} +: BeatW] <= i_dc_rdata;
        if (w_is_mat && r_beat != LastBeat) r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Matrix beats are word-aligned and wrap modulo 2^32.
  assign o_dc_addr = w_is_mat ? ({r_addr[31:2], 2'b00} + (32'(r_beat) << 2)) : r_addr;
  assign o_dc_req  = (r_state == StReq);
  assign o_dc_we   = (r_state == StReq) && w_is_store;

  assign o_me_valid   = (r_state == StDone);
  assign o_dc_r_valid = o_me_valid && (r_op == OpLoad) && !r_misalign;
  assign o_dc_f_valid = o_me_valid && (r_op == OpFlw) && !r_misalign;
  assign o_dc_m_valid = o_me_valid && (r_op == OpSml) && !r_misalign;
  assign o_dc_data_r  = r_data_r;
  assign o_dc_data_f  = r_data_f;
  assign o_dc_data_m  = r_data_m;
  assign o_misalign   = r_misalign;

  assign o_alu_out2_res_r = r_res_r;
  assign o_alu_out2_res_f = r_res_f;
  assign o_alu_out2_res_m = r_res_m;

endmodule

// File: tb/tb_me_stage.sv
// Directed vector bench for me_stage: scalar table plus matrix, stall and reset sequences.
module tb_me_stage;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, FL = 7'b0000111, FS = 7'b0100111;
  localparam logic [6:0] SML = 7'b1111011, SMS = 7'b1111111, ALU = 7'b0110011, ALUI = 7'b0010011;

  logic         clk = 1'b0, rst, ex_valid, ready, wb_ready, me_valid;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [31:0]  addr, st_r, st_f, res_r, res_f, alu_r, alu_f, data_r, data_f;
  logic [511:0] st_m, res_m, alu_m, data_m;
  logic         r_valid, f_valid, m_valid, dc_req, dc_we, dc_gnt, dc_rvalid, misalign;
  logic [31:0]  dc_addr, dc_wdata, dc_rdata;
  logic [3:0]   dc_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  me_stage dut (
    .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .o_ready(ready),
    .i_opcode(opcode), .i_funct3(funct3), .i_addr(addr),
    .i_st_r(st_r), .i_st_f(st_f), .i_st_m(st_m),
    .i_res_r(res_r), .i_res_f(res_f), .i_res_m(res_m),
    .i_wb_ready(wb_ready), .o_me_valid(me_valid),
    .o_alu_out2_res_r(alu_r), .o_alu_out2_res_f(alu_f), .o_alu_out2_res_m(alu_m),
    .o_dc_r_valid(r_valid), .o_dc_f_valid(f_valid), .o_dc_m_valid(m_valid),
    .o_dc_data_r(data_r), .o_dc_data_f(data_f), .o_dc_data_m(data_m),
    .o_dc_req(dc_req), .o_dc_we(dc_we), .o_dc_addr(dc_addr),
    .o_dc_wdata(dc_wdata), .o_dc_wstrb(dc_wstrb),
    .i_dc_gnt(dc_gnt), .i_dc_rvalid(dc_rvalid), .i_dc_rdata(dc_rdata),
    .o_misalign(misalign)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, sr, sf, rd;
    bit          req, we;
    logic [3:0]  strb;
    logic [31:0] wd;
    bit          rv, fv;
    logic [31:0] d;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] a, sr, sf, rd, input bit req, we,
                              input logic [3:0] strb, input logic [31:0] wd,
                              input bit rv, fv, input logic [31:0] d);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.a = a; v.sr = sr; v.sf = sf; v.rd = rd;
    v.req = req; v.we = we; v.strb = strb; v.wd = wd; v.rv = rv; v.fv = fv; v.d = d;
    return v;
  endfunction

  task automatic drive_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
    opcode = op; funct3 = f3; addr = a; ex_valid = 1'b1;
  endtask

  // Issue one scalar op and act as a zero-wait cache; checks the request and the WB view.
  task automatic run_vec(input vec_t v, input logic [31:0] rr);
    bit seen, pend, done;
    @(negedge clk);
    st_r = v.sr; st_f = v.sf; res_r = rr;
    drive_op(v.op, v.f3, v.a);
    @(negedge clk);
    ex_valid = 1'b0;
    seen = 0; pend = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      dc_gnt = 1'b0; dc_rvalid = 1'b0;
      if (me_valid) done = 1;
      else if (dc_req) begin
        if (!seen) begin
          chk({v.name, " addr"}, dc_addr, v.a);
          chk({v.name, " we"}, dc_we, v.we);
          if (v.we) begin
            chk({v.name, " wstrb"}, dc_wstrb, v.strb);
            chk({v.name, " wdata"}, dc_wdata, v.wd);
          end
        end
        seen = 1; dc_gnt = 1'b1; pend = 1;
      end else if (pend) begin
        dc_rvalid = 1'b1; dc_rdata = v.rd; pend = 0;
      end
      if (!done) @(negedge clk);
    end
    dc_gnt = 1'b0; dc_rvalid = 1'b0;
    chk({v.name, " done"}, done, 1'b1);
    chk({v.name, " req seen"}, seen, v.req);
    chk({v.name, " r_valid"}, r_valid, v.rv);
    chk({v.name, " f_valid"}, f_valid, v.fv);
    chk({v.name, " m_valid"}, m_valid, 1'b0);
    if (v.rv) chk({v.name, " data_r"}, data_r, v.d);
    if (v.fv) chk({v.name, " data_f"}, data_f, v.d);
    chk({v.name, " res_r"}, alu_r, rr);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk({v.name, " me_valid drop"}, me_valid, 1'b0);
  endtask

  vec_t         vecs[11];
  logic [511:0] exp_m;
  logic [31:0]  last_a;
  int           nreq, bad;
  bit           pend, done;

  initial begin
    vecs[0]  = mk("lb",   LD,  3'b000, 32'h103, 0, 0, 32'h80FF_FF00, 1, 0, 0, 0, 1, 0, 32'hFFFF_FF80);
    vecs[1]  = mk("lbu",  LD,  3'b100, 32'h101, 0, 0, 32'h1234_A5FF, 1, 0, 0, 0, 1, 0, 32'h0000_00A5);
    vecs[2]  = mk("lh",   LD,  3'b001, 32'h202, 0, 0, 32'h8001_7FFF, 1, 0, 0, 0, 1, 0, 32'hFFFF_8001);
    vecs[3]  = mk("lhu",  LD,  3'b101, 32'h200, 0, 0, 32'h8001_F00F, 1, 0, 0, 0, 1, 0, 32'h0000_F00F);
    vecs[4]  = mk("lw",   LD,  3'b010, 32'h300, 0, 0, 32'hDEAD_BEEF, 1, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
    vecs[5]  = mk("flw",  FL,  3'b010, 32'h400, 0, 0, 32'h3F80_0000, 1, 0, 0, 0, 0, 1, 32'h3F80_0000);
    vecs[6]  = mk("sh",   ST,  3'b001, 32'h202, 32'h0000_1234, 0, 0, 1, 1, 4'b1100,
                  32'h1234_0000, 0, 0, 0);
    vecs[7]  = mk("sb",   ST,  3'b000, 32'h101, 32'h0000_00AB, 0, 0, 1, 1, 4'b0010,
                  32'h0000_AB00, 0, 0, 0);
    vecs[8]  = mk("sw",   ST,  3'b010, 32'h500, 32'hCAFE_F00D, 0, 0, 1, 1, 4'b1111,
                  32'hCAFE_F00D, 0, 0, 0);
    vecs[9]  = mk("fsw",  FS,  3'b010, 32'h504, 0, 32'h4049_0FDB, 0, 1, 1, 4'b1111,
                  32'h4049_0FDB, 0, 0, 0);
    vecs[10] = mk("alu",  ALU, 3'b000, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; ex_valid = 0; opcode = 0; funct3 = 0; addr = 0; st_r = 0; st_f = 0;
    res_r = 0; res_f = 32'h5A5A_0001; res_m = {16{32'hC0DE_0000}}; wb_ready = 0;
    dc_gnt = 0; dc_rvalid = 0; dc_rdata = 0;
    for (int i = 0; i < 16; i++) st_m[32*i +: 32] = 32'hA000_0000 | i;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst ready", ready, 1'b1);
    chk("rst me_valid", me_valid, 1'b0);
    chk("rst dc_req", dc_req, 1'b0);
    chk("rst dc_we", dc_we, 1'b0);
    chk("rst misalign", misalign, 1'b0);
    chk("rst dc_addr", dc_addr, 32'h0);
    chk("rst wstrb", dc_wstrb, 4'h0);
    chk("rst wdata", dc_wdata, 32'h0);
    chk("rst dc_valids", {r_valid, f_valid, m_valid}, 3'b000);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], {16'hA5A5, 16'(i)});
    chk("res_f passthrough", alu_f, 32'h5A5A_0001);
    chk("res_m passthrough", alu_m, {16{32'hC0DE_0000}});

    // sml from the top of the address space; rdata carries the beat index
    @(negedge clk);
    drive_op(SML, 3'b010, 32'hFFFF_FFC0);
    @(negedge clk);
    ex_valid = 0; nreq = 0; bad = 0; pend = 0; done = 0; last_a = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      dc_gnt = 0; dc_rvalid = 0;
      if (me_valid) done = 1;
      else if (dc_req) begin
        if (dc_addr !== 32'hFFFF_FFC0 + 32'(nreq * 4) || dc_we) bad++;
        last_a = dc_addr; nreq++; dc_gnt = 1; pend = 1;
      end else if (pend) begin
        dc_rvalid = 1; dc_rdata = 32'(nreq - 1); pend = 0;
      end
      if (!done) @(negedge clk);
    end
    dc_gnt = 0; dc_rvalid = 0;
    for (int i = 0; i < 16; i++) exp_m[32*i +: 32] = i;
    chk("sml done", done, 1'b1);
    chk("sml beats", nreq, 16);
    chk("sml bad beats", bad, 0);
    chk("sml last addr", last_a, 32'hFFFF_FFFC);
    chk("sml valids", {r_valid, f_valid, m_valid}, 3'b001);
    chk("sml data", data_m, exp_m);
    wb_ready = 1; @(negedge clk); wb_ready = 0;

    // grant stall then WB stall, with stray rvalid while still in REQ
    drive_op(LD, 3'b010, 32'h600);
    @(negedge clk);
    ex_valid = 0; bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (!dc_req || dc_addr !== 32'h600 || ready || dc_we) bad++;
      dc_rvalid = 1; dc_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
    end
    chk("gnt stall stable", bad, 0);
    chk("gnt stall req", dc_req, 1'b1);
    dc_gnt = 1; dc_rvalid = 1;
    @(negedge clk);
    dc_gnt = 0; dc_rvalid = 0;
    chk("wait no early done", me_valid, 1'b0);
    dc_rvalid = 1; dc_rdata = 32'h1357_2468;
    @(negedge clk);
    dc_rvalid = 0; bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (!me_valid || !r_valid || data_r !== 32'h1357_2468 || ready || dc_req) bad++;
      @(negedge clk);
    end
    chk("wb stall stable", bad, 0);
    wb_ready = 1; res_r = 32'h2222_2222;
    drive_op(ALUI, 3'b000, 32'h0);
    #1 chk("done ready w/ wb_ready", ready, 1'b1);
    @(negedge clk);
    ex_valid = 0; wb_ready = 0;
    chk("b2b me_valid", me_valid, 1'b1);
    chk("b2b res_r", alu_r, 32'h2222_2222);
    chk("b2b r_valid", r_valid, 1'b0);
    wb_ready = 1; @(negedge clk); wb_ready = 0;
    chk("b2b drain", me_valid, 1'b0);

    // sms, reset while waiting on beat 7
    drive_op(SMS, 3'b010, 32'h800);
    @(negedge clk);
    ex_valid = 0; nreq = 0; bad = 0; pend = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      dc_gnt = 0; dc_rvalid = 0;
      if (dc_req) begin
        if (dc_wdata !== st_m[32*nreq +: 32] || !dc_we || dc_wstrb !== 4'hF ||
            dc_addr !== 32'h800 + 32'(nreq * 4)) bad++;
        nreq++; dc_gnt = 1; pend = 1;
      end else if (pend && nreq == 8) begin
        rst = 1; dc_rvalid = 1; done = 1;
      end else if (pend) begin
        dc_rvalid = 1; pend = 0;
      end
      @(negedge clk);
    end
    rst = 0; dc_rvalid = 0; dc_gnt = 0;
    chk("sms reset reached", done, 1'b1);
    chk("sms beats before rst", nreq, 8);
    chk("sms beat data", bad, 0);
    chk("post-rst dc_req", dc_req, 1'b0);
    chk("post-rst me_valid", me_valid, 1'b0);
    chk("post-rst ready", ready, 1'b1);
    dc_rvalid = 1; dc_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dc_rvalid = 0;
    chk("stray rvalid me_valid", me_valid, 1'b0);
    chk("stray rvalid dc_req", dc_req, 1'b0);
    chk("stray rvalid ready", ready, 1'b1);

`ifdef ME_MISALIGN_CHK_EN
    drive_op(LD, 3'b010, 32'h101);
    @(negedge clk);
    ex_valid = 0;
    chk("mis dc_req", dc_req, 1'b0);
    chk("mis misalign", misalign, 1'b1);
    chk("mis me_valid", me_valid, 1'b1);
    chk("mis r_valid", r_valid, 1'b0);
    wb_ready = 1; @(negedge clk); wb_ready = 0;
    chk("mis clear", misalign, 1'b0);
`else
    run_vec(mk("lw unaligned", LD, 3'b010, 32'h101, 0, 0, 32'h0BAD_F00D, 1, 0, 0, 0, 1, 0,
               32'h0BAD_F00D), 32'h3333_3333);
    chk("no-chk misalign", misalign, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
